// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage controller.
package mem_stage_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned RW_DEF   = 5;

  // Bit positions inside the {regwrite, memtoreg} control pair
  localparam int unsigned REGWRITE = 1;
  localparam int unsigned MEMTOREG = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_ctrl_if
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle; a non-retiring cycle leaves a bubble.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_regwrite,
  input  logic          i_memtoreg,
  input  logic [DW-1:0] i_read_data,
  input  logic [DW-1:0] i_alu_result,
  input  logic [RW-1:0] i_wreg,
  output logic          o_valid,
  output logic          o_regwrite,
  output logic          o_memtoreg,
  output logic [DW-1:0] o_read_data,
  output logic [DW-1:0] o_alu_result,
  output logic [RW-1:0] o_wreg
);

  logic          r_valid;
  logic          r_regwrite;
  logic          r_memtoreg;
  logic [DW-1:0] r_read_data;
  logic [DW-1:0] r_alu_result;
  logic [RW-1:0] r_wreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_wreg       <= '0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_regwrite   <= i_regwrite;
        r_memtoreg   <= i_memtoreg;
        r_read_data  <= i_read_data;
        r_alu_result <= i_alu_result;
        r_wreg       <= i_wreg;
      end
    end
  end

  assign o_valid      = r_valid;
  // A bubble must never write the register file, whatever the stale payload says
  assign o_regwrite   = r_valid & r_regwrite;
  assign o_memtoreg   = r_memtoreg;
  assign o_read_data  = r_read_data;
  assign o_alu_result = r_alu_result;
  assign o_wreg       = r_wreg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS MEM stage: data-memory bus FSM, pipeline stall, branch resolve, MEM/WB register.
// Optional bus-timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [1:0]        ex_wb_ctl,
  input  logic              ex_branch,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_zero,
  input  logic [DW-1:0]     ex_alu_result,
  input  logic [DW-1:0]     ex_rdata2,
  input  logic [RW-1:0]     ex_wreg,
  mem_stage_ctrl_if.master  dm,
  output logic              mem_stall,
  output logic              mem_pcsrc,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [DW-1:0]     wb_read_data,
  output logic [DW-1:0]     wb_alu_result,
  output logic [RW-1:0]     wb_wreg,
  output logic              timeout_err
);

  state_e        r_state;
  logic          r_we;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_memop;
  logic          w_start;
  logic          w_done;
  logic          w_abort;
  logic          w_retire;
  logic          w_regwrite;
  logic [DW-1:0] w_read_data;

  assign w_memop = ex_memread | ex_memwrite;
  assign w_start = (r_state == IDLE) & ex_valid & w_memop;
  assign w_done  = (r_state == ACCESS) & dm.dm_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // Abort on the cycle that would be the TIMEOUT_CYCLES-th wait without ready
  assign w_abort = (r_state == ACCESS) & ~dm.dm_ready &
                   (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ACCESS) && !dm.dm_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= ACCESS;
            r_we    <= ex_memwrite;
            r_addr  <= {ex_alu_result[DW-1:2], 2'b00};
            r_wdata <= ex_rdata2;
          end
        end
        ACCESS: begin
          if (dm.dm_ready || w_abort) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dm.dm_req   = (r_state == ACCESS);
  assign dm.dm_we    = r_we;
  assign dm.dm_addr  = r_addr;
  assign dm.dm_wdata = r_wdata;

  assign mem_stall = w_start | ((r_state == ACCESS) & ~dm.dm_ready & ~w_abort);
  assign mem_pcsrc = ex_valid & ex_branch & ex_zero & ~mem_stall;

  // Non-memory ops retire straight from IDLE; memory ops on ready or abort
  assign w_retire    = ((r_state == IDLE) & ex_valid & ~w_memop) | w_done | w_abort;
  assign w_regwrite  = ex_wb_ctl[REGWRITE] & ~w_abort;
  assign w_read_data = (w_done & ~r_we) ? dm.dm_rdata : '0;

  mem_wb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_retire),
    .i_regwrite   (w_regwrite),
    .i_memtoreg   (ex_wb_ctl[MEMTOREG]),
    .i_read_data  (w_read_data),
    .i_alu_result (ex_alu_result),
    .i_wreg       (ex_wreg),
    .o_valid      (wb_valid),
    .o_regwrite   (wb_regwrite),
    .o_memtoreg   (wb_memtoreg),
    .o_read_data  (wb_read_data),
    .o_alu_result (wb_alu_result),
    .o_wreg       (wb_wreg)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed spec scenarios plus randomized instruction
// stream against a transaction-level reference model. Define MEM_TIMEOUT_EN to test the abort.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_branch, ex_memread, ex_memwrite, ex_zero;
  logic [1:0]  ex_wb_ctl;
  logic [31:0] ex_alu_result, ex_rdata2;
  logic [4:0]  ex_wreg;
  logic        mem_stall, mem_pcsrc, wb_valid, wb_regwrite, wb_memtoreg, timeout_err;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_wreg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DW(32)) dm_bus ();

  mem_stage_ctrl #(
    .DW (32),
    .RW (5)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_wb_ctl     (ex_wb_ctl),
    .ex_branch     (ex_branch),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_zero       (ex_zero),
    .ex_alu_result (ex_alu_result),
    .ex_rdata2     (ex_rdata2),
    .ex_wreg       (ex_wreg),
    .dm            (dm_bus),
    .mem_stall     (mem_stall),
    .mem_pcsrc     (mem_pcsrc),
    .wb_valid      (wb_valid),
    .wb_regwrite   (wb_regwrite),
    .wb_memtoreg   (wb_memtoreg),
    .wb_read_data  (wb_read_data),
    .wb_alu_result (wb_alu_result),
    .wb_wreg       (wb_wreg),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    bit          valid;
    bit [1:0]    ctl;
    bit          branch, rd, wr, zero;
    logic [31:0] alu, rdata2;
    logic [4:0]  wreg;
    int          waits;
    logic [31:0] mrd;
  } instr_t;

  typedef struct {
    int          stall_cyc, req_cyc, wbv_mid;
    bit          bus_stable, pcsrc_last, pcsrc_stalled;
    logic        we, wbv, wbrw, wbm2r;
    logic [31:0] addr, wdata, wbrd, wbalu;
    logic [4:0]  wreg;
  } obs_t;

  function automatic instr_t mk(bit v, bit [1:0] ctl, bit br, bit rd, bit wr, bit z,
                                logic [31:0] alu, logic [31:0] d2, logic [4:0] wreg,
                                int waits, logic [31:0] mrd);
    instr_t t;
    t.valid = v; t.ctl = ctl; t.branch = br; t.rd = rd; t.wr = wr; t.zero = z;
    t.alu = alu; t.rdata2 = d2; t.wreg = wreg; t.waits = waits; t.mrd = mrd;
    return t;
  endfunction

  // Transaction-level expectation: a memory op occupies waits+2 cycles, stalls all but the last
  function automatic obs_t model(instr_t in);
    obs_t e = '{default: 0};
    bit memop = in.valid && (in.rd || in.wr);
    e.stall_cyc  = memop ? in.waits + 1 : 0;
    e.req_cyc    = e.stall_cyc;
    e.bus_stable = 1'b1;
    e.addr       = in.alu & 32'hFFFF_FFFC;
    e.we         = in.wr;
    e.wdata      = in.rdata2;
    e.pcsrc_last = in.valid && in.branch && in.zero;
    e.wbv        = in.valid;
    e.wbrw       = in.valid && in.ctl[1];
    e.wbm2r      = in.ctl[0];
    e.wbrd       = (memop && !in.wr) ? in.mrd : 32'h0;
    e.wbalu      = in.alu;
    e.wreg       = in.wreg;
    return e;
  endfunction

  // Drives one EX/MEM entry and acts as the memory; called at posedge+1, returns at posedge+1
  task automatic exec(input instr_t in, output obs_t ob);
    bit memop = in.valid && (in.rd || in.wr);
    int ncyc  = memop ? in.waits + 2 : 1;
    ob = '{default: 0};
    ob.bus_stable = 1'b1;
    ex_valid = in.valid; ex_wb_ctl = in.ctl; ex_branch = in.branch; ex_memread = in.rd;
    ex_memwrite = in.wr; ex_zero = in.zero; ex_alu_result = in.alu; ex_rdata2 = in.rdata2;
    ex_wreg = in.wreg;
    dm_bus.dm_ready = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (memop && c == ncyc - 1) begin
        dm_bus.dm_ready = 1'b1;
        dm_bus.dm_rdata = in.mrd;
      end
      @(negedge clk);
      if (mem_stall) ob.stall_cyc++;
      if (mem_stall && mem_pcsrc) ob.pcsrc_stalled = 1'b1;
      if (c == ncyc - 1) ob.pcsrc_last = mem_pcsrc;
      if (c > 0 && wb_valid) ob.wbv_mid++;
      if (dm_bus.dm_req) begin
        if (ob.req_cyc == 0) begin
          ob.addr = dm_bus.dm_addr; ob.we = dm_bus.dm_we; ob.wdata = dm_bus.dm_wdata;
        end else if (dm_bus.dm_addr !== ob.addr || dm_bus.dm_we !== ob.we ||
                     dm_bus.dm_wdata !== ob.wdata) begin
          ob.bus_stable = 1'b0;
        end
        ob.req_cyc++;
      end
      @(posedge clk); #1;
    end
    dm_bus.dm_ready = 1'b0;
    dm_bus.dm_rdata = $urandom;
    ex_valid = 1'b0;
    ob.wbv = wb_valid; ob.wbrw = wb_regwrite; ob.wbm2r = wb_memtoreg;
    ob.wbrd = wb_read_data; ob.wbalu = wb_alu_result; ob.wreg = wb_wreg;
  endtask

  task automatic test_reset();
    logic [75:0] got;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_wb_ctl = 2'b11; ex_branch = 1'b0; ex_memread = 1'b0;
    ex_memwrite = 1'b0; ex_zero = 1'b0; ex_alu_result = 32'h0; ex_rdata2 = 32'h0; ex_wreg = '0;
    dm_bus.dm_ready = 1'b1; dm_bus.dm_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {dm_bus.dm_req, mem_stall, mem_pcsrc, wb_valid, wb_regwrite, wb_memtoreg,
           wb_read_data, wb_alu_result, wb_wreg, timeout_err};
    n_tests++;
    if (got !== 76'h0) begin
      n_fail++; $display("FAIL reset outputs got=%h want=0", got);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    dm_bus.dm_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b0 || dm_bus.dm_req !== 1'b0) begin
      n_fail++; $display("FAIL reset stray ready got=%b%b want=00", wb_valid, dm_bus.dm_req);
    end
  endtask

  task automatic test_add();
    obs_t o;
    exec(mk(1, 2'b10, 0, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 0, 0), o);
    n_tests++;
    if (o.stall_cyc !== 0) begin n_fail++; $display("FAIL add stall got=%0d want=0", o.stall_cyc); end
    n_tests++;
    if ({o.wbv, o.wbrw} !== 2'b11) begin
      n_fail++; $display("FAIL add wb_valid/regwrite got=%b%b want=11", o.wbv, o.wbrw);
    end
    n_tests++;
    if (o.wbalu !== 32'h10 || o.wreg !== 5'd5) begin
      n_fail++; $display("FAIL add result got=%h/%0d want=10/5", o.wbalu, o.wreg);
    end
  endtask

  task automatic test_load();
    obs_t o;
    exec(mk(1, 2'b11, 0, 1, 0, 0, 32'h0000_0040, 32'h0, 5'd8, 3, 32'hDEAD_BEEF), o);
    n_tests++;
    if (o.stall_cyc !== 4) begin n_fail++; $display("FAIL lw stall got=%0d want=4", o.stall_cyc); end
    n_tests++;
    if (o.addr !== 32'h40 || o.we !== 1'b0 || !o.bus_stable) begin
      n_fail++; $display("FAIL lw bus got=%h we=%b stable=%b want=40 we=0 stable=1",
                         o.addr, o.we, o.bus_stable);
    end
    n_tests++;
    if (o.wbrd !== 32'hDEAD_BEEF || o.wbm2r !== 1'b1 || o.wbv !== 1'b1) begin
      n_fail++; $display("FAIL lw wb got=%h m2r=%b v=%b want=deadbeef 1 1", o.wbrd, o.wbm2r, o.wbv);
    end
    n_tests++;
    if (o.wbv_mid !== 0) begin n_fail++; $display("FAIL lw bubble got=%0d want=0", o.wbv_mid); end
  endtask

  task automatic test_store();
    obs_t o;
    exec(mk(1, 2'b00, 0, 0, 1, 0, 32'h0000_0083, 32'h0000_1234, 5'd0, 1, 32'h5555_5555), o);
    n_tests++;
    if (o.we !== 1'b1 || o.addr !== 32'h80 || o.wdata !== 32'h1234) begin
      n_fail++; $display("FAIL sw bus got=%b/%h/%h want=1/80/1234", o.we, o.addr, o.wdata);
    end
    n_tests++;
    if (o.wbrw !== 1'b0 || o.wbv !== 1'b1) begin
      n_fail++; $display("FAIL sw wb got=rw%b v%b want=rw0 v1", o.wbrw, o.wbv);
    end
  endtask

  task automatic test_branch();
    obs_t o;
    exec(mk(1, 2'b00, 1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 0, 0), o);
    n_tests++;
    if (o.pcsrc_last !== 1'b1) begin n_fail++; $display("FAIL beq taken got=%b want=1", o.pcsrc_last); end
    exec(mk(1, 2'b00, 1, 0, 0, 0, 32'h4, 32'h0, 5'd0, 0, 0), o);
    n_tests++;
    if (o.pcsrc_last !== 1'b0) begin n_fail++; $display("FAIL beq nottaken got=%b want=0", o.pcsrc_last); end
    exec(mk(0, 2'b00, 1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 0, 0), o);
    n_tests++;
    if (o.pcsrc_last !== 1'b0 || o.wbv !== 1'b0) begin
      n_fail++; $display("FAIL beq invalid got=%b%b want=00", o.pcsrc_last, o.wbv);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    ex_valid = 1'b1; ex_wb_ctl = 2'b11; ex_branch = 1'b0; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_alu_result = 32'h0000_0100; ex_wreg = 5'd3; dm_bus.dm_ready = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (dm_bus.dm_req !== 1'b1) begin n_fail++; $display("FAIL rst-mid req before got=%b want=1", dm_bus.dm_req); end
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dm_bus.dm_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst-mid immediate got=%b%b want=00", dm_bus.dm_req, wb_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dm_bus.dm_ready = 1'b1; dm_bus.dm_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dm_bus.dm_ready = 1'b0;
    n_tests++;
    if (wb_valid !== 1'b0 || dm_bus.dm_req !== 1'b0) begin
      n_fail++; $display("FAIL rst-mid late ready got=%b%b want=00", wb_valid, dm_bus.dm_req);
    end
    exec(mk(1, 2'b10, 0, 0, 0, 0, 32'h0000_0777, 32'h0, 5'd9, 0, 0), o);
    n_tests++;
    if (o.wbv !== 1'b1 || o.wbalu !== 32'h777 || o.wreg !== 5'd9 || o.stall_cyc !== 0) begin
      n_fail++; $display("FAIL rst-mid add got=%b/%h/%0d/%0d want=1/777/9/0",
                         o.wbv, o.wbalu, o.wreg, o.stall_cyc);
    end
  endtask

  task automatic test_random();
    instr_t in;
    obs_t   o, e;
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 4);
      bit v = ($urandom_range(0, 9) != 0);
      logic [31:0] a = $urandom, d = $urandom, m = $urandom;
      logic [4:0]  r = 5'($urandom);
      int w = $urandom_range(0, 3);
      bit z = 1'($urandom);
      unique case (kind)
        0: in = mk(v, 2'b10, 0, 0, 0, z, a, d, r, w, m);
        1: in = mk(v, 2'b11, 0, 1, 0, z, a, d, r, w, m);
        2: in = mk(v, {1'b0, 1'($urandom)}, 0, 0, 1, z, a, d, r, w, m);
        3: in = mk(v, 2'b00, 1, 0, 0, z, a, d, r, w, m);
        default: in = mk(v, 2'($urandom), 0, 1, 1, z, a, d, r, w, m);
      endcase
      e = model(in);
      exec(in, o);
      n_tests++;
      if (o.stall_cyc !== e.stall_cyc || o.req_cyc !== e.req_cyc) begin
        n_fail++; $display("FAIL rnd[%0d] stall/req got=%0d/%0d want=%0d/%0d",
                           i, o.stall_cyc, o.req_cyc, e.stall_cyc, e.req_cyc);
      end
      if (e.req_cyc > 0) begin
        n_tests++;
        if (o.addr !== e.addr || o.we !== e.we || o.wdata !== e.wdata || !o.bus_stable) begin
          n_fail++; $display("FAIL rnd[%0d] bus got=%h/%b/%h/s%b want=%h/%b/%h/s1",
                             i, o.addr, o.we, o.wdata, o.bus_stable, e.addr, e.we, e.wdata);
        end
        n_tests++;
        if (o.wbrd !== e.wbrd) begin
          n_fail++; $display("FAIL rnd[%0d] read_data got=%h want=%h", i, o.wbrd, e.wbrd);
        end
      end
      n_tests++;
      if (o.pcsrc_last !== e.pcsrc_last || o.pcsrc_stalled || o.wbv_mid !== 0) begin
        n_fail++; $display("FAIL rnd[%0d] pcsrc/bubble got=%b/%b/%0d want=%b/0/0",
                           i, o.pcsrc_last, o.pcsrc_stalled, o.wbv_mid, e.pcsrc_last);
      end
      n_tests++;
      if (o.wbv !== e.wbv || o.wbrw !== e.wbrw) begin
        n_fail++; $display("FAIL rnd[%0d] valid/regwrite got=%b%b want=%b%b",
                           i, o.wbv, o.wbrw, e.wbv, e.wbrw);
      end
      if (e.wbv) begin
        n_tests++;
        if (o.wbalu !== e.wbalu || o.wreg !== e.wreg || o.wbm2r !== e.wbm2r) begin
          n_fail++; $display("FAIL rnd[%0d] payload got=%h/%0d/%b want=%h/%0d/%b",
                             i, o.wbalu, o.wreg, o.wbm2r, e.wbalu, e.wreg, e.wbm2r);
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int  stalls = 0;
    bit  released = 1'b0;
    ex_valid = 1'b1; ex_wb_ctl = 2'b11; ex_branch = 1'b0; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_alu_result = 32'h0000_0200; ex_wreg = 5'd4; dm_bus.dm_ready = 1'b0;
    for (int c = 0; c < 20 && !released; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else released = 1'b1;
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    n_tests++;
    if (!released || stalls !== 4) begin
      n_fail++; $display("FAIL timeout stall got=%0d released=%b want=4 released=1", stalls, released);
    end
    n_tests++;
    if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || timeout_err !== 1'b1 || dm_bus.dm_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout retire got=v%b rw%b err%b req%b want=v1 rw0 err1 req0",
                         wb_valid, wb_regwrite, timeout_err, dm_bus.dm_req);
    end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout sticky got=%b want=1", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    obs_t o;
    exec(mk(1, 2'b11, 0, 1, 0, 0, 32'h0000_0204, 32'h0, 5'd4, 40, 32'h0BAD_F00D), o);
    n_tests++;
    if (o.stall_cyc !== 41 || o.wbrd !== 32'h0BAD_F00D || o.wbrw !== 1'b1) begin
      n_fail++; $display("FAIL long wait got=%0d/%h/%b want=41/0badf00d/1", o.stall_cyc, o.wbrd, o.wbrw);
    end
    n_tests++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err tied got=%b want=0", timeout_err); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_reset_mid_access();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
